// File: rtl/mips_pkg.sv
// Shared encodings and pipeline-register layouts for the mips_core pipeline.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [3:0] {
        AluAdd, AluSub, AluAnd, AluOr, AluXor, AluNor,
        AluSlt, AluSll, AluSrl, AluSra, AluLui, AluPassA
    } alu_op_e;

    typedef enum logic [1:0] {MemWord, MemByte, MemHalf} mem_size_e;

    typedef struct packed {
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        alu_op_e     alu_op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
        logic [31:0] rt_val;
        logic [4:0]  dest;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mul;
        mem_size_e   mem_size;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] rt_val;
        logic [4:0]  dest;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mul;
        mem_size_e   mem_size;
        logic [63:0] product;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  dest;
        logic        reg_write;
        logic        mul;
        logic [63:0] product;
    } mem_wb_t;

endpackage

// File: rtl/mips_alu.sv
// Combinational integer ALU; shifts act on b by shamt.
module mips_alu
    import mips_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    input  alu_op_e     alu_op,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        case (alu_op)
            AluAdd:   result = a + b;
            AluSub:   result = a - b;
            AluAnd:   result = a & b;
            AluOr:    result = a | b;
            AluXor:   result = a ^ b;
            AluNor:   result = ~(a | b);
            AluSlt:   result = {31'b0, $signed(a) < $signed(b)};
            AluSll:   result = b << shamt;
            AluSrl:   result = b >> shamt;
            AluSra:   result = $signed(b) >>> shamt;
            AluLui:   result = {b[15:0], 16'h0};
            AluPassA: result = a;
            default:  result = a;
        endcase
    end

endmodule

// File: rtl/mips_core.sv
// 5-stage MIPS32-subset pipeline without hazard detection or forwarding;
// the only bypass is WB -> ID within the same cycle.
module mips_core
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] read_instruction,
    input  logic [31:0] read_data,
    output logic [31:0] instruction_address,
    output logic [31:0] data_address,
    output logic [31:0] write_data,
    output logic        mem_write,
    output logic        mem_read
);

    logic [31:0] pc_q;
    logic [31:0] regs_q [32];
    logic [31:0] hi_q, lo_q;
    if_id_t      if_id_q;
    id_ex_t      id_ex_q, id_ex_d;
    ex_mem_t     ex_mem_q, ex_mem_d;
    mem_wb_t     mem_wb_q, mem_wb_d;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm_sext, imm_zext, rs_val, rt_val, hi_rd, lo_rd;
    logic [31:0] alu_result, load_val;
    logic        wb_we;

    assign opcode   = if_id_q.instr[31:26];
    assign rs       = if_id_q.instr[25:21];
    assign rt       = if_id_q.instr[20:16];
    assign rd       = if_id_q.instr[15:11];
    assign shamt    = if_id_q.instr[10:6];
    assign funct    = if_id_q.instr[5:0];
    assign imm_sext = {{16{if_id_q.instr[15]}}, if_id_q.instr[15:0]};
    assign imm_zext = {16'h0, if_id_q.instr[15:0]};

    // Same-cycle WB results are visible to the ID read; $0 is never written.
    assign wb_we  = mem_wb_q.reg_write && (mem_wb_q.dest != 5'd0);
    assign rs_val = (wb_we && mem_wb_q.dest == rs) ? mem_wb_q.result : regs_q[rs];
    assign rt_val = (wb_we && mem_wb_q.dest == rt) ? mem_wb_q.result : regs_q[rt];
    assign hi_rd  = mem_wb_q.mul ? mem_wb_q.product[63:32] : hi_q;
    assign lo_rd  = mem_wb_q.mul ? mem_wb_q.product[31:0]  : lo_q;

    assign instruction_address = pc_q;

    always_comb begin
        id_ex_d        = '0;
        id_ex_d.a      = rs_val;
        id_ex_d.b      = rt_val;
        id_ex_d.rt_val = rt_val;
        id_ex_d.shamt  = shamt;
        id_ex_d.dest   = rd;
        if (opcode == OP_RTYPE) begin
            id_ex_d.reg_write = 1'b1;
            case (funct)
                FN_ADD:  id_ex_d.alu_op = AluAdd;
                FN_SUB:  id_ex_d.alu_op = AluSub;
                FN_AND:  id_ex_d.alu_op = AluAnd;
                FN_OR:   id_ex_d.alu_op = AluOr;
                FN_XOR:  id_ex_d.alu_op = AluXor;
                FN_NOR:  id_ex_d.alu_op = AluNor;
                FN_SLT:  id_ex_d.alu_op = AluSlt;
                FN_SLL:  id_ex_d.alu_op = AluSll;
                FN_SRL:  id_ex_d.alu_op = AluSrl;
                FN_SRA:  id_ex_d.alu_op = AluSra;
                FN_MFHI: begin
                    id_ex_d.alu_op = AluPassA;
                    id_ex_d.a      = hi_rd;
                end
                FN_MFLO: begin
                    id_ex_d.alu_op = AluPassA;
                    id_ex_d.a      = lo_rd;
                end
                FN_MULTU: begin
                    id_ex_d.reg_write = 1'b0;
                    id_ex_d.mul       = 1'b1;
                end
                default: id_ex_d.reg_write = 1'b0;
            endcase
        end else begin
            id_ex_d.dest      = rt;
            id_ex_d.b         = imm_sext;
            id_ex_d.reg_write = 1'b1;
            case (opcode)
                OP_ADDI: id_ex_d.alu_op = AluAdd;
                OP_SLTI: id_ex_d.alu_op = AluSlt;
                OP_ANDI: begin
                    id_ex_d.alu_op = AluAnd;
                    id_ex_d.b      = imm_zext;
                end
                OP_ORI: begin
                    id_ex_d.alu_op = AluOr;
                    id_ex_d.b      = imm_zext;
                end
                OP_XORI: begin
                    id_ex_d.alu_op = AluXor;
                    id_ex_d.b      = imm_zext;
                end
                OP_LUI: id_ex_d.alu_op = AluLui;
                OP_LW:  id_ex_d.mem_read = 1'b1;
                OP_LBU: begin
                    id_ex_d.mem_read = 1'b1;
                    id_ex_d.mem_size = MemByte;
                end
                OP_LHU: begin
                    id_ex_d.mem_read = 1'b1;
                    id_ex_d.mem_size = MemHalf;
                end
                OP_SW: begin
                    id_ex_d.reg_write = 1'b0;
                    id_ex_d.mem_write = 1'b1;
                end
                default: id_ex_d.reg_write = 1'b0;
            endcase
        end
    end

    mips_alu u_alu (
        .a      (id_ex_q.a),
        .b      (id_ex_q.b),
        .shamt  (id_ex_q.shamt),
        .alu_op (id_ex_q.alu_op),
        .result (alu_result)
    );

    always_comb begin
        ex_mem_d            = '0;
        ex_mem_d.alu_result = alu_result;
        ex_mem_d.rt_val     = id_ex_q.rt_val;
        ex_mem_d.dest       = id_ex_q.dest;
        ex_mem_d.reg_write  = id_ex_q.reg_write;
        ex_mem_d.mem_read   = id_ex_q.mem_read;
        ex_mem_d.mem_write  = id_ex_q.mem_write;
        ex_mem_d.mul        = id_ex_q.mul;
        ex_mem_d.mem_size   = id_ex_q.mem_size;
        ex_mem_d.product    = 64'(id_ex_q.a) * 64'(id_ex_q.b);
    end

    assign data_address = ex_mem_q.alu_result;
    assign write_data   = ex_mem_q.rt_val;
    assign mem_write    = ex_mem_q.mem_write;
    assign mem_read     = ex_mem_q.mem_read;

    always_comb begin
        load_val = read_data;
        case (ex_mem_q.mem_size)
            MemByte: begin
                case (ex_mem_q.alu_result[1:0])
                    2'd0:    load_val = {24'h0, read_data[7:0]};
                    2'd1:    load_val = {24'h0, read_data[15:8]};
                    2'd2:    load_val = {24'h0, read_data[23:16]};
                    default: load_val = {24'h0, read_data[31:24]};
                endcase
            end
            MemHalf: load_val = ex_mem_q.alu_result[1] ? {16'h0, read_data[31:16]}
                                                       : {16'h0, read_data[15:0]};
            default: load_val = read_data;
        endcase
    end

    always_comb begin
        mem_wb_d           = '0;
        mem_wb_d.result    = ex_mem_q.mem_read ? load_val : ex_mem_q.alu_result;
        mem_wb_d.dest      = ex_mem_q.dest;
        mem_wb_d.reg_write = ex_mem_q.reg_write;
        mem_wb_d.mul       = ex_mem_q.mul;
        mem_wb_d.product   = ex_mem_q.product;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            if_id_q  <= '0;
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            pc_q     <= pc_q + 32'd4;
            if_id_q  <= '{instr: read_instruction};
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (wb_we) regs_q[mem_wb_q.dest] <= mem_wb_q.result;
            if (mem_wb_q.mul) {hi_q, lo_q} <= mem_wb_q.product;
        end
    end

endmodule

// File: tb/tb_mips_core.sv
// Directed program bench for mips_core with an ISA-level model that applies
// each register result only to instructions at least three slots later.
module tb_mips_core;

    localparam int NM = 72;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] read_instruction, read_data, instruction_address;
    logic [31:0] data_address, write_data;
    logic        mem_write, mem_read;

    logic [31:0] imem [64];
    logic [31:0] dmem [64] = '{0: 32'd8, 1: 32'd100, 4: 32'd1, 5: 32'd2,
                               8: 32'd356, 9: 32'd65540, default: 32'd0};
    logic [31:0] m_mem [64];

    logic        exp_mr [NM];
    logic        exp_mw [NM];
    logic [31:0] exp_addr [NM];
    logic [31:0] exp_wd [NM];
    logic        p_we [NM];
    logic [4:0]  p_rd [NM];
    logic [31:0] p_val [NM];
    logic        p_mul [NM];
    logic [63:0] p_prod [NM];

    // Hand-computed results: word 2, then words 16..39.
    logic [31:0] lit_v [25] = '{32'd100,
        32'd3, 32'd3, 32'd0, 32'd1, 32'd4, 32'd0, 32'd1, 32'hFFFF_FFFC, 32'd3, 32'd1,
        32'hFFFF_FFFF, 32'd3, 32'd0, 32'd3, 32'd3, 32'd1, 32'hFFFF_0000,
        32'h64, 32'h4, 32'h1, 32'd16, 32'd0, 32'd0, 32'hFFFF_FFFE};

    int n_cmp = 0;
    int n_bad = 0;
    int plen  = 0;

    always #5 clk = ~clk;

    assign read_instruction = (instruction_address < 32'd256) ? imem[instruction_address[7:2]]
                                                             : 32'h0;
    assign read_data = dmem[data_address[7:2]];

    always @(posedge clk) if (mem_write) dmem[data_address[7:2]] <= write_data;

    mips_core #(.RESET_PC(32'h0)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .read_instruction    (read_instruction),
        .read_data           (read_data),
        .instruction_address (instruction_address),
        .data_address        (data_address),
        .write_data          (write_data),
        .mem_write           (mem_write),
        .mem_read            (mem_read)
    );

    function automatic logic [31:0] rop(input logic [5:0] fn, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] iop(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic emit(input logic [31:0] w);
        imem[plen] = w;
        plen++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_model();
        logic [31:0] r [32];
        logic [31:0] hi, lo, ins, a, b, simm, zimm, addr, word, val;
        logic [5:0]  op, fn;
        logic [4:0]  sh, dst;
        logic        we;
        hi = 0;
        lo = 0;
        for (int i = 0; i < 32; i++) r[i] = 0;
        for (int i = 0; i < 64; i++) m_mem[i] = dmem[i];
        for (int j = 0; j < NM; j++) begin
            if (j >= 3) begin
                if (p_we[j-3] && p_rd[j-3] != 0) r[p_rd[j-3]] = p_val[j-3];
                if (p_mul[j-3]) {hi, lo} = p_prod[j-3];
            end
            ins  = (j < 64) ? imem[j] : 32'h0;
            op   = ins[31:26];
            fn   = ins[5:0];
            sh   = ins[10:6];
            a    = r[ins[25:21]];
            b    = r[ins[20:16]];
            simm = {{16{ins[15]}}, ins[15:0]};
            zimm = {16'h0, ins[15:0]};
            addr = a + simm;
            word = m_mem[addr[7:2]];
            we = 1; dst = ins[20:16]; val = 0;
            p_mul[j] = 0; p_prod[j] = 0;
            exp_mr[j] = 0; exp_mw[j] = 0; exp_addr[j] = 0; exp_wd[j] = 0;
            case (op)
                6'h00: begin
                    dst = ins[15:11];
                    case (fn)
                        6'h20: val = a + b;
                        6'h22: val = a - b;
                        6'h24: val = a & b;
                        6'h25: val = a | b;
                        6'h26: val = a ^ b;
                        6'h27: val = ~(a | b);
                        6'h2A: val = ($signed(a) < $signed(b)) ? 1 : 0;
                        6'h00: val = b << sh;
                        6'h02: val = b >> sh;
                        6'h03: val = $signed(b) >>> sh;
                        6'h10: val = hi;
                        6'h12: val = lo;
                        6'h19: begin
                            we = 0;
                            p_mul[j] = 1;
                            p_prod[j] = 64'(a) * 64'(b);
                        end
                        default: we = 0;
                    endcase
                end
                6'h08: val = a + simm;
                6'h0A: val = ($signed(a) < $signed(simm)) ? 1 : 0;
                6'h0C: val = a & zimm;
                6'h0D: val = a | zimm;
                6'h0E: val = a ^ zimm;
                6'h0F: val = {ins[15:0], 16'h0};
                6'h23, 6'h24, 6'h25: begin
                    exp_mr[j] = 1;
                    exp_addr[j] = addr;
                    if (op == 6'h23) val = word;
                    else if (op == 6'h24) val = (word >> (8 * addr[1:0])) & 32'hFF;
                    else val = (word >> (16 * addr[1])) & 32'hFFFF;
                end
                6'h2B: begin
                    we = 0;
                    exp_mw[j] = 1;
                    exp_addr[j] = addr;
                    exp_wd[j] = b;
                    m_mem[addr[7:2]] = b;
                end
                default: we = 0;
            endcase
            p_we[j] = we;
            p_rd[j] = dst;
            p_val[j] = val;
        end
    endtask

    // Instruction fetched c cycles after reset release is in MEM at cycle c+3.
    task automatic cycle_check(input int c);
        int idx;
        logic e_mr, e_mw;
        idx  = c - 3;
        e_mr = (idx >= 0 && idx < NM) ? exp_mr[idx] : 1'b0;
        e_mw = (idx >= 0 && idx < NM) ? exp_mw[idx] : 1'b0;
        check($sformatf("pc@%0d", c), instruction_address, 32'(4 * c));
        check($sformatf("mem_read@%0d", c), {31'b0, mem_read}, {31'b0, e_mr});
        check($sformatf("mem_write@%0d", c), {31'b0, mem_write}, {31'b0, e_mw});
        if (e_mr || e_mw) check($sformatf("data_address@%0d", c), data_address, exp_addr[idx]);
        if (e_mw) check($sformatf("write_data@%0d", c), write_data, exp_wd[idx]);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
        emit(iop(6'h23, 2, 0, 16'h0));
        emit(iop(6'h23, 3, 0, 16'h4));
        emit(iop(6'h23, 8, 0, 16'h10));
        emit(iop(6'h23, 9, 0, 16'h14));
        emit(iop(6'h2B, 3, 2, 16'h0));
        emit(32'h0);
        emit(rop(6'h20, 10, 8, 9, 0));
        emit(rop(6'h25, 11, 8, 9, 0));
        emit(rop(6'h24, 12, 8, 9, 0));
        emit(rop(6'h02, 13, 0, 9, 1));
        emit(rop(6'h00, 14, 0, 9, 1));
        emit(rop(6'h2A, 15, 9, 8, 0));
        emit(rop(6'h2A, 16, 8, 9, 0));
        emit(rop(6'h27, 17, 8, 9, 0));
        emit(rop(6'h26, 18, 8, 9, 0));
        emit(rop(6'h22, 19, 9, 8, 0));
        emit(rop(6'h22, 20, 8, 9, 0));
        emit(iop(6'h08, 21, 9, 16'h1));
        emit(iop(6'h0C, 22, 9, 16'h1));
        emit(iop(6'h0D, 23, 9, 16'h1));
        emit(iop(6'h0E, 24, 9, 16'h1));
        emit(iop(6'h0A, 25, 9, 16'h4));
        emit(iop(6'h0F, 26, 0, 16'hFFFF));
        emit(iop(6'h24, 27, 0, 16'h20));
        emit(iop(6'h25, 28, 0, 16'h24));
        emit(iop(6'h24, 29, 0, 16'h21));
        emit(rop(6'h19, 0, 9, 2, 0));
        emit(rop(6'h03, 30, 0, 17, 1));
        emit(32'h0);
        emit(32'h0);
        emit(rop(6'h12, 7, 0, 0, 0));
        emit(rop(6'h10, 6, 0, 0, 0));
        emit(rop(6'h20, 5, 7, 0, 0));  // back-to-back on $7: sees the stale value
        emit(32'h0);
        emit(32'h0);
        for (int k = 0; k < 20; k++) emit(iop(6'h2B, 5'(10 + k), 0, 16'(16'h40 + 4 * k)));
        emit(iop(6'h2B, 7, 0, 16'h90));
        emit(iop(6'h2B, 6, 0, 16'h94));
        emit(iop(6'h2B, 5, 0, 16'h98));
        emit(iop(6'h2B, 30, 0, 16'h9C));
        run_model();

        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            cycle_check(c);
        end

        // Asynchronous reset in the middle of a cycle, while a load is in MEM.
        #2 rst = 1'b1;
        #1;
        check("rst_pc", instruction_address, 32'h0);
        check("rst_mem_read", {31'b0, mem_read}, 32'h0);
        check("rst_mem_write", {31'b0, mem_write}, 32'h0);
        check("rst_data_address", data_address, 32'h0);
        check("rst_write_data", write_data, 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;

        for (int c = 0; c <= 70; c++) begin
            @(negedge clk);
            cycle_check(c);
        end

        for (int w = 0; w < 64; w++) check($sformatf("dmem[%0d]", w), dmem[w], m_mem[w]);
        check("lit_dmem[2]", dmem[2], lit_v[0]);
        check("lit_model[2]", m_mem[2], lit_v[0]);
        for (int k = 1; k < 25; k++) begin
            check($sformatf("lit_dmem[%0d]", 15 + k), dmem[15 + k], lit_v[k]);
            check($sformatf("lit_model[%0d]", 15 + k), m_mem[15 + k], lit_v[k]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
